// File: rtl/vga_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : vga_ctrl_if
// Brief   : VRAM read port plus VGA DAC / CPU-side status bundle for vga_ctrl.
// Revision: 1.0
// ============================================================================
interface vga_ctrl_if;
    logic [15:0] vgac_addr;
    logic [15:0] vgac_data;
    logic        vga_hsync;
    logic        vga_vsync;
    logic        vga_blank_n;
    logic        vga_clk;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vblank;
    logic        frame_pulse;

    modport master (
        output vgac_addr,
        input  vgac_data,
        output vga_hsync,
        output vga_vsync,
        output vga_blank_n,
        output vga_clk,
        output vga_r,
        output vga_g,
        output vga_b,
        output vblank,
        output frame_pulse
    );

    modport slave (
        input  vgac_addr,
        output vgac_data,
        input  vga_hsync,
        input  vga_vsync,
        input  vga_blank_n,
        input  vga_clk,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  vblank,
        input  frame_pulse
    );
endinterface
`default_nettype wire

// File: rtl/vga_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : vga_ctrl
// Brief   : 640x480@60 scan-out of a 240xIMG_H BGR555 bitmap, 2x scaled and
//           centred, with one pixel period of fetch/output pipeline.
// Revision: 1.0
// ============================================================================
module vga_ctrl #(
    parameter int CLK_DIV  = 2,
    parameter int X_OFF    = 80,
    parameter int Y_OFF    = 80,
    parameter int IMG_H    = 160,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  wire logic  clk,
    input  wire logic  rst,
    vga_ctrl_if.master vif
);

    localparam int DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] c_HALF     = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] c_H_ACTIVE   = 10'd640;
    localparam logic [9:0] c_H_SYNC_BEG = 10'd656;
    localparam logic [9:0] c_H_SYNC_END = 10'd752;
    localparam logic [9:0] c_H_LAST     = 10'd799;

    localparam logic [9:0] c_V_ACTIVE   = 10'(V_ACTIVE);
    localparam logic [9:0] c_V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] c_V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] c_V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [9:0]  c_X_BEG = 10'(X_OFF);
    localparam logic [9:0]  c_X_END = 10'(X_OFF + 480);
    localparam logic [9:0]  c_Y_BEG = 10'(Y_OFF);
    localparam logic [9:0]  c_Y_END = 10'(Y_OFF + 2 * IMG_H);
    localparam logic [15:0] c_IMG_W = 16'd240;

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h;
    logic [9:0]       r_v;
    logic [15:0]      r_base;
    logic [15:0]      r_addr;
    logic             r_s1_hs;
    logic             r_s1_vs;
    logic             r_s1_bn;
    logic             r_s1_vis;
    logic             r_hs;
    logic             r_vs;
    logic             r_bn;
    logic             r_vga_clk;
    logic [7:0]       r_r;
    logic [7:0]       r_g;
    logic [7:0]       r_b;
    logic             r_vblank;
    logic             r_fp;

    logic [DIV_W-1:0] w_div_nxt;
    logic             w_tick;
    logic             w_h_last;
    logic             w_v_last;
    logic [9:0]       w_h_nxt;
    logic [9:0]       w_v_nxt;
    logic             w_x_in;
    logic             w_y_in;
    logic             w_win;
    logic             w_nv_in;
    logic [9:0]       w_hrel;
    logic [15:0]      w_gx;
    logic [15:0]      w_addr;
    logic             w_hs;
    logic             w_vs;
    logic             w_bn;
    logic [14:0]      w_pix;

    assign w_tick    = (r_div == '0);
    assign w_div_nxt = (r_div == c_DIV_LAST) ? '0 : r_div + 1'b1;

    assign w_h_last = (r_h == c_H_LAST);
    assign w_v_last = (r_v == c_V_LAST);
    assign w_h_nxt  = w_h_last ? 10'd0 : r_h + 10'd1;
    assign w_v_nxt  = !w_h_last ? r_v : (w_v_last ? 10'd0 : r_v + 10'd1);

    assign w_x_in  = (r_h >= c_X_BEG) && (r_h < c_X_END);
    assign w_y_in  = (r_v >= c_Y_BEG) && (r_v < c_Y_END);
    assign w_win   = w_x_in && w_y_in;
    assign w_nv_in = (w_v_nxt >= c_Y_BEG) && (w_v_nxt < c_Y_END);

    // r_base holds gy*240 for the current line, so the address is just base + gx.
    assign w_hrel = r_h - c_X_BEG;
    assign w_gx   = 16'(w_hrel >> 1);
    assign w_addr = w_win ? (r_base + w_gx) : 16'd0;

    assign w_hs = !((r_h >= c_H_SYNC_BEG) && (r_h < c_H_SYNC_END));
    assign w_vs = !((r_v >= c_V_SYNC_BEG) && (r_v < c_V_SYNC_END));
    assign w_bn = (r_h < c_H_ACTIVE) && (r_v < c_V_ACTIVE);

    assign w_pix = 15'(vif.vgac_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div     <= '0;
            r_h       <= '0;
            r_v       <= '0;
            r_base    <= '0;
            r_addr    <= '0;
            r_s1_hs   <= 1'b1;
            r_s1_vs   <= 1'b1;
            r_s1_bn   <= 1'b0;
            r_s1_vis  <= 1'b0;
            r_hs      <= 1'b1;
            r_vs      <= 1'b1;
            r_bn      <= 1'b0;
            r_vga_clk <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
            r_vblank  <= 1'b1;
            r_fp      <= 1'b0;
        end else begin
            r_div     <= w_div_nxt;
            r_vga_clk <= (w_div_nxt < c_HALF);
            r_fp      <= w_tick && w_h_last && w_v_last;
            if (w_tick) begin
                r_h <= w_h_nxt;
                r_v <= w_v_nxt;
                if (w_h_last) begin
                    if (w_v_nxt == c_Y_BEG) begin
                        r_base <= '0;
                    end else if (w_nv_in && (w_v_nxt[0] == c_Y_BEG[0])) begin
                        r_base <= r_base + c_IMG_W;
                    end
                end
                r_addr   <= w_addr;
                r_s1_hs  <= w_hs;
                r_s1_vs  <= w_vs;
                r_s1_bn  <= w_bn;
                r_s1_vis <= w_win && w_bn;
                r_vblank <= !w_y_in;
                // VRAM data for the previous pixel has landed by this tick.
                r_hs <= r_s1_hs;
                r_vs <= r_s1_vs;
                r_bn <= r_s1_bn;
                if (r_s1_vis) begin
                    r_r <= {w_pix[4:0],   w_pix[4:2]};
                    r_g <= {w_pix[9:5],   w_pix[9:7]};
                    r_b <= {w_pix[14:10], w_pix[14:12]};
                end else begin
                    r_r <= '0;
                    r_g <= '0;
                    r_b <= '0;
                end
            end
        end
    end

    assign vif.vgac_addr   = r_addr;
    assign vif.vga_hsync   = r_hs;
    assign vif.vga_vsync   = r_vs;
    assign vif.vga_blank_n = r_bn;
    assign vif.vga_clk     = r_vga_clk;
    assign vif.vga_r       = r_r;
    assign vif.vga_g       = r_g;
    assign vif.vga_b       = r_b;
    assign vif.vblank      = r_vblank;
    assign vif.frame_pulse = r_fp;

endmodule
`default_nettype wire

// File: tb/tb_vga_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_vga_ctrl
// Brief   : Self-checking bench for vga_ctrl on a vertically shortened raster.
// Revision: 1.0
// ============================================================================
module tb_vga_ctrl;

    localparam int D     = 2;
    localparam int XO    = 80;
    localparam int YO    = 2;
    localparam int IH    = 4;
    localparam int VA    = 12;
    localparam int VF    = 1;
    localparam int VS    = 2;
    localparam int VB    = 1;
    localparam int VT    = VA + VF + VS + VB;
    localparam int FRAME = 800 * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n = 0;
    bit   in_rst = 1'b0;
    bit   started = 1'b0;
    int   mode = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    logic [15:0] mem_q = '0;

    vga_ctrl_if vif ();

    vga_ctrl #(
        .CLK_DIV (D),
        .X_OFF   (XO),
        .Y_OFF   (YO),
        .IMG_H   (IH),
        .V_ACTIVE(VA),
        .V_FP    (VF),
        .V_SYNC  (VS),
        .V_BP    (VB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vif(vif)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input int md, input int a);
        if (md == 1) return 16'h7FFF;
        case (a)
            0:       return 16'h7C1F;
            1:       return 16'h0000;
            2:       return 16'h8000;
            default: return 16'(a * 40503) ^ 16'(a >> 2);
        endcase
    endfunction

    always @(posedge clk) mem_q <= mem_word(mode, int'(vif.vgac_addr));
    assign vif.vgac_data = mem_q;

    always @(posedge clk) begin
        n      <= rst ? 0 : n + 1;
        in_rst <= rst;
        if (rst) started <= 1'b1;
    end

    function automatic bit win(input int h, input int v);
        return (h >= XO) && (h < XO + 480) && (v >= YO) && (v < YO + 2 * IH);
    endfunction

    function automatic int addr_of(input int p);
        int h, v;
        h = p % 800;
        v = p / 800;
        if (!win(h, v)) return 0;
        return ((v - YO) / 2) * 240 + (h - XO) / 2;
    endfunction

    function automatic logic [7:0] ex(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    // {addr, hsync, vsync, blank_n, vga_clk, r, g, b, vblank, frame_pulse}
    function automatic logic [45:0] model(input int cyc, input bit rs, input int md);
        int pa, q, h, v, va;
        logic [15:0] w;
        logic hs, vs, bn, vb, vc, fp;
        logic [23:0] rgb;
        logic [15:0] ad;
        if (rs || cyc == 0) return {16'd0, 4'b1100, 24'd0, 2'b10};
        pa = (cyc - 1) / D;
        ad = 16'(addr_of(pa % FRAME));
        va = (pa % FRAME) / 800;
        vb = !((va >= YO) && (va < YO + 2 * IH));
        vc = (cyc % D) < (D / 2);
        fp = ((cyc - 1) % D == 0) && (pa % FRAME == FRAME - 1);
        if (pa == 0) begin
            hs = 1'b1; vs = 1'b1; bn = 1'b0; rgb = '0;
        end else begin
            q  = (pa - 1) % FRAME;
            h  = q % 800;
            v  = q / 800;
            hs = !((h >= 656) && (h < 752));
            vs = !((v >= VA + VF) && (v < VA + VF + VS));
            bn = (h < 640) && (v < VA);
            if (win(h, v) && bn) begin
                w   = mem_word(md, addr_of(q));
                rgb = {ex(w[4:0]), ex(w[9:5]), ex(w[14:10])};
            end else begin
                rgb = '0;
            end
        end
        return {ad, hs, vs, bn, vc, rgb, vb, fp};
    endfunction

    always @(negedge clk) begin
        logic [45:0] act, exp_v;
        if (started) begin
            exp_v = model(n, in_rst, mode);
            act = {vif.vgac_addr, vif.vga_hsync, vif.vga_vsync, vif.vga_blank_n,
                   vif.vga_clk, vif.vga_r, vif.vga_g, vif.vga_b, vif.vblank,
                   vif.frame_pulse};
            n_chk++;
            if (act !== exp_v) begin
                n_fail++;
                $display("FAIL model cyc=%0d got=%h want=%h", n, act, exp_v);
            end
        end
    end

    task automatic lit(input string nm, input int act, input int want);
        n_chk++;
        if (act != want) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", nm, act, want);
        end
    endtask

    task automatic finish_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    endtask

    task automatic wait_n(input int t);
        int k;
        k = 0;
        while (n != t && k < 60000) begin
            @(negedge clk);
            k++;
        end
        if (n != t) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_n got=%0d want=%0d", n, t);
            finish_run();
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        wait_n(1313); lit("hs_655", int'(vif.vga_hsync), 1);
        wait_n(1315); lit("hs_656", int'(vif.vga_hsync), 0);
        wait_n(1505); lit("hs_751", int'(vif.vga_hsync), 0);
        wait_n(1507); lit("hs_752", int'(vif.vga_hsync), 1);
        wait_n(3359); lit("addr_79_2", int'(vif.vgac_addr), 0);
        wait_n(3361); lit("addr_80_2", int'(vif.vgac_addr), 0);
        wait_n(3363);
        lit("addr_81_2", int'(vif.vgac_addr), 0);
        lit("rgb_80_2", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 24'hFF00FF);
        wait_n(3365); lit("addr_82_2", int'(vif.vgac_addr), 1);
        wait_n(3367);
        lit("rgb_zero", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 0);
        lit("bn_82_2", int'(vif.vga_blank_n), 1);
        wait_n(3371); lit("rgb_bit15", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 0);

        // Abort mid-frame at h=300, v=5.
        wait_n(8600);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        lit("rst_outs", int'({vif.vga_hsync, vif.vga_vsync, vif.vga_blank_n, vif.vblank,
                              vif.frame_pulse, vif.vga_clk}), 6'b110100);
        lit("rst_rgb_addr", int'({vif.vga_r, vif.vga_g, vif.vga_b, vif.vgac_addr}), 0);
        @(negedge clk);
        rst = 1'b0;

        wait_n(4323);
        lit("rgb_560_2", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 0);
        lit("bn_560_2", int'(vif.vga_blank_n), 1);
        wait_n(6561);  lit("addr_80_4", int'(vif.vgac_addr), 240);
        wait_n(15519); lit("addr_last", int'(vif.vgac_addr), 959);
        wait_n(15999); lit("vblank_9", int'(vif.vblank), 0);
        wait_n(16001); lit("vblank_10", int'(vif.vblank), 1);
        wait_n(18881); lit("bn_639_11", int'(vif.vga_blank_n), 1);
        wait_n(19203);
        lit("vs_12", int'(vif.vga_vsync), 1);
        lit("bn_12", int'(vif.vga_blank_n), 0);
        wait_n(20803); lit("vs_13", int'(vif.vga_vsync), 0);
        wait_n(24001); lit("vs_14", int'(vif.vga_vsync), 0);
        wait_n(24003); lit("vs_15", int'(vif.vga_vsync), 1);
        wait_n(25598); lit("fp_early", int'(vif.frame_pulse), 0);
        wait_n(25599); lit("fp_first", int'(vif.frame_pulse), 1);
        mode = 1;
        wait_n(25600); lit("fp_single", int'(vif.frame_pulse), 0);

        wait_n(27363); lit("white_80_1", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 0);
        wait_n(28961); lit("white_79_2", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 0);
        wait_n(28963); lit("white_80_2", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 24'hFFFFFF);
        wait_n(29923); lit("white_560_2", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 0);
        wait_n(41763); lit("white_80_10", int'({vif.vga_r, vif.vga_g, vif.vga_b}), 0);
        wait_n(51199); lit("fp_second", int'(vif.frame_pulse), 1);
        wait_n(51210);
        finish_run();
    end

endmodule
`default_nettype wire
